// File: rtl/fpu_half_fma_sequencer_if.sv
// rtl/fpu_half_fma_sequencer_if.sv - shared types and request/datapath interfaces for the half-precision FMA sequencer
package fpu_half_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [3:0] {
        FPU_HALF_ADD   = 4'd0,
        FPU_HALF_SUB   = 4'd1,
        FPU_HALF_MUL   = 4'd2,
        FPU_HALF_DIV   = 4'd3,
        FPU_HALF_SQRT  = 4'd4,
        FPU_HALF_MIN   = 4'd5,
        FPU_HALF_MAX   = 4'd6,
        FPU_HALF_MADD  = 4'd7,
        FPU_HALF_MSUB  = 4'd8,
        FPU_HALF_NMADD = 4'd9,
        FPU_HALF_NMSUB = 4'd10
    } fpu_operation_t;
endpackage

interface fpu_req_if;
    import fpu_half_pkg::*;

    logic              req_valid;
    logic              req_ready;
    fpu_operation_t    req_op;
    logic [WORD_W-1:0] req_a;
    logic [WORD_W-1:0] req_b;
    logic [WORD_W-1:0] req_c;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_result;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_c, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_c, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err
    );
endinterface

interface fpu_dp_if;
    import fpu_half_pkg::*;

    logic              fpu_start;
    fpu_operation_t    fpu_operation;
    logic [WORD_W-1:0] fpu_a;
    logic [WORD_W-1:0] fpu_b;
    logic              fpu_done;
    logic [WORD_W-1:0] fpu_out;

    modport master (
        output fpu_start, fpu_operation, fpu_a, fpu_b,
        input  fpu_done, fpu_out
    );

    modport slave (
        input  fpu_start, fpu_operation, fpu_a, fpu_b,
        output fpu_done, fpu_out
    );
endinterface

// File: rtl/fpu_half_fma_sequencer.sv
// rtl/fpu_half_fma_sequencer.sv - front-end sequencer issuing half ADD/SUB/MUL and unfused MUL+ADD multiply-add ops
module fpu_half_fma_sequencer
    import fpu_half_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic      CLK,
    input  logic      nRST,
    fpu_req_if.slave  req,
    fpu_dp_if.master  dp
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        STEP1,
        STEP2,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fpu_operation_t op_q, op_d;
    logic [15:0]    a_q, a_d;
    logic [15:0]    b_q, b_d;
    logic [15:0]    c_q, c_d;
    logic [15:0]    p_q, p_d;
    logic [15:0]    res_q, res_d;
    logic           err_q, err_d;

    logic is_fused;
    logic is_plain;
    logic neg_p;
    logic neg_c;
    logic req_plain;
    logic req_fused;

    // Only the low half of each word carries data; the rest is deliberately dropped.
    logic unused_upper;
    assign unused_upper = ^{req.req_a[WORD_W-1:16], req.req_b[WORD_W-1:16],
                            req.req_c[WORD_W-1:16], dp.fpu_out[WORD_W-1:16]};

    assign is_fused  = op_q inside {FPU_HALF_MADD, FPU_HALF_MSUB, FPU_HALF_NMADD, FPU_HALF_NMSUB};
    assign is_plain  = op_q inside {FPU_HALF_ADD, FPU_HALF_SUB, FPU_HALF_MUL};
    assign neg_p     = op_q inside {FPU_HALF_NMADD, FPU_HALF_NMSUB};
    assign neg_c     = op_q inside {FPU_HALF_MSUB, FPU_HALF_NMADD};
    assign req_plain = req.req_op inside {FPU_HALF_ADD, FPU_HALF_SUB, FPU_HALF_MUL};
    assign req_fused = req.req_op inside {FPU_HALF_MADD, FPU_HALF_MSUB, FPU_HALF_NMADD, FPU_HALF_NMSUB};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= FPU_HALF_ADD;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        res_d   = res_q;
        err_d   = err_q;

        req.req_ready    = 1'b0;
        req.resp_valid   = 1'b0;
        req.resp_result  = {16'b0, res_q};
        req.resp_err     = err_q;
        dp.fpu_start     = 1'b0;
        dp.fpu_operation = FPU_HALF_ADD;
        dp.fpu_a         = '0;
        dp.fpu_b         = '0;

        case (state_q)
            IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) begin
                    op_d  = req.req_op;
                    a_d   = req.req_a[15:0];
                    b_d   = req.req_b[15:0];
                    c_d   = req.req_c[15:0];
                    cnt_d = '0;
                    if (req_plain || req_fused) begin
                        state_d = STEP1;
                    end else begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end

            STEP1, STEP2: begin
                dp.fpu_start = 1'b1;
                if (state_q == STEP1) begin
                    dp.fpu_operation = is_plain ? op_q : FPU_HALF_MUL;
                    dp.fpu_a         = {16'b0, a_q};
                    dp.fpu_b         = {16'b0, b_q};
                end else begin
                    // Sign flips touch bit 15 only so NaN payloads pass through unchanged.
                    dp.fpu_operation = FPU_HALF_ADD;
                    dp.fpu_a         = {16'b0, p_q ^ {neg_p, 15'b0}};
                    dp.fpu_b         = {16'b0, c_q ^ {neg_c, 15'b0}};
                end

                if (dp.fpu_done) begin
                    if (state_q == STEP1 && is_fused) begin
                        p_d     = dp.fpu_out[15:0];
                        cnt_d   = '0;
                        state_d = STEP2;
                    end else begin
                        res_d   = dp.fpu_out[15:0];
                        err_d   = 1'b0;
                        state_d = RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                req.resp_valid = 1'b1;
                if (req.resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpu_half_fma_sequencer.sv
// tb/tb_fpu_half_fma_sequencer.sv - scoreboard bench with a real-arithmetic half-precision reference and datapath stub
module tb_fpu_half_fma_sequencer;
    import fpu_half_pkg::*;

    localparam int TO = 16;

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          lat;
        int          acc;
        int          stall;
    } exp_t;

    logic CLK;
    logic nRST;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    exp_t sb[$];

    fpu_req_if rq();
    fpu_dp_if  dp();

    fpu_half_fma_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .req  (rq),
        .dp   (dp)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        real v;
        if (e == 0) v = m * pow2(-24);
        else        v = (m + 1024) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    // Exact real value rounded once to half precision, ties to even.
    function automatic logic [15:0] r2h(input real x);
        logic s = (x < 0.0);
        real  ax = s ? -x : x;
        int   e = -14;
        real  m;
        int   mi;
        real  fr;
        if (ax == 0.0) return 16'h0000;
        while (ax >= pow2(e + 1) && e < 16) e++;
        m  = ax / pow2(e - 10);
        mi = $rtoi(m);
        fr = m - mi;
        if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 2048) begin mi = 1024; e++; end
        if (e > 15) return {s, 5'h1f, 10'h000};
        if (mi < 1024) return {s, 5'd0, mi[9:0]};
        return {s, 5'(e + 15), 10'(mi - 1024)};
    endfunction

    task automatic model(input fpu_operation_t op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input int d,
                         output logic [15:0] r, output logic e, output int lat);
        real p;
        bit  ok = 1;
        r = 16'h0;
        e = 1'b0;
        p = h2r(r2h(h2r(a) * h2r(b)));
        case (op)
            FPU_HALF_ADD:   begin r = r2h(h2r(a) + h2r(b)); lat = d + 2; end
            FPU_HALF_SUB:   begin r = r2h(h2r(a) - h2r(b)); lat = d + 2; end
            FPU_HALF_MUL:   begin r = r2h(h2r(a) * h2r(b)); lat = d + 2; end
            FPU_HALF_MADD:  begin r = r2h(p + h2r(c));      lat = 2 * d + 3; end
            FPU_HALF_MSUB:  begin r = r2h(p - h2r(c));      lat = 2 * d + 3; end
            FPU_HALF_NMADD: begin r = r2h(-p - h2r(c));     lat = 2 * d + 3; end
            FPU_HALF_NMSUB: begin r = r2h(-p + h2r(c));     lat = 2 * d + 3; end
            default:        begin e = 1'b1; lat = 1; ok = 0; end
        endcase
        if (ok && d >= TO) begin
            r = 16'h0;
            e = 1'b1;
            lat = TO + 1;
        end
    endtask

    function automatic logic [15:0] rand_half();
        return {1'($urandom), 5'($urandom_range(13, 17)), 10'($urandom)};
    endfunction

    // Datapath stub: answers each step after dp_delay idle cycles, real-arithmetic result.
    int             dp_delay = 0;
    int             wait_cnt = 0;
    int             start_cnt = 0;
    bit             in_step = 0;
    fpu_operation_t s_op;
    logic [31:0]    s_a, s_b;
    logic [15:0]    dp_res;

    always @(negedge CLK) begin
        if (nRST && dp.fpu_start) begin
            start_cnt++;
            chk("fpu_a_upper", {16'b0, dp.fpu_a[31:16]}, 32'h0);
            chk("fpu_b_upper", {16'b0, dp.fpu_b[31:16]}, 32'h0);
            chk("dp_op_legal", {31'b0, dp.fpu_operation inside {FPU_HALF_ADD, FPU_HALF_SUB, FPU_HALF_MUL}}, 32'h1);
            if (in_step) begin
                chk("step_op_stable", {28'b0, dp.fpu_operation}, {28'b0, s_op});
                chk("step_a_stable", dp.fpu_a, s_a);
                chk("step_b_stable", dp.fpu_b, s_b);
            end
            s_op = dp.fpu_operation;
            s_a  = dp.fpu_a;
            s_b  = dp.fpu_b;
            if (wait_cnt >= dp_delay) begin
                case (dp.fpu_operation)
                    FPU_HALF_SUB: dp_res = r2h(h2r(dp.fpu_a[15:0]) - h2r(dp.fpu_b[15:0]));
                    FPU_HALF_MUL: dp_res = r2h(h2r(dp.fpu_a[15:0]) * h2r(dp.fpu_b[15:0]));
                    default:      dp_res = r2h(h2r(dp.fpu_a[15:0]) + h2r(dp.fpu_b[15:0]));
                endcase
                dp.fpu_done = 1'b1;
                dp.fpu_out  = {16'hFFFF, dp_res};
                wait_cnt    = 0;
                in_step     = 0;
            end else begin
                dp.fpu_done = 1'b0;
                dp.fpu_out  = $urandom;
                wait_cnt++;
                in_step     = 1;
            end
        end else begin
            dp.fpu_done = 1'($urandom);
            dp.fpu_out  = $urandom;
            wait_cnt    = 0;
            in_step     = 0;
        end
    end

    // Response monitor: pops the scoreboard on the first cycle of each response.
    exp_t cur;
    bit   seen = 0;
    bit   cur_ok = 0;
    int   stall_left = 0;

    always @(negedge CLK) begin
        if (!nRST) begin
            seen = 0;
            rq.resp_ready = 1'b0;
        end else if (rq.resp_valid) begin
            if (!seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    cur_ok = 0;
                    stall_left = 0;
                    n_checks++;
                    $display("FAIL unexpected_resp: got result %h err %b, required no response", rq.resp_result, rq.resp_err);
                end else begin
                    cur = sb.pop_front();
                    cur_ok = 1;
                    chk("resp_result", rq.resp_result, {16'b0, cur.res});
                    chk("resp_err", {31'b0, rq.resp_err}, {31'b0, cur.err});
                    chk("latency", cyc + 1 - cur.acc, cur.lat);
                    stall_left = cur.stall;
                end
            end else if (cur_ok) begin
                chk("hold_result", rq.resp_result, {16'b0, cur.res});
                chk("hold_err", {31'b0, rq.resp_err}, {31'b0, cur.err});
                chk("hold_req_ready", {31'b0, rq.req_ready}, 32'h0);
            end
            if (stall_left > 0) begin
                rq.resp_ready = 1'b0;
                stall_left--;
            end else begin
                rq.resp_ready = 1'b1;
            end
        end else begin
            seen = 0;
            rq.resp_ready = 1'($urandom);
        end
    end

    task automatic send(input fpu_operation_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input int d, input int stall, input bit push);
        int   n = 0;
        exp_t x;
        @(negedge CLK);
        rq.req_valid = 1'b1;
        rq.req_op    = op;
        rq.req_a     = a;
        rq.req_b     = b;
        rq.req_c     = c;
        while (!rq.req_ready && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (!rq.req_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: got req_ready 0 for %0d cycles, required 1", n);
            rq.req_valid = 1'b0;
            return;
        end
        dp_delay = d;
        model(op, a[15:0], b[15:0], c[15:0], d, x.res, x.err, x.lat);
        x.acc   = cyc + 1;
        x.stall = stall;
        if (push) sb.push_back(x);
        @(negedge CLK);
        rq.req_valid = 1'b0;
        rq.req_op    = fpu_operation_t'(4'($urandom_range(0, 10)));
        rq.req_a     = $urandom;
        rq.req_b     = $urandom;
        rq.req_c     = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while ((sb.size() != 0 || !rq.req_ready) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0 || !rq.req_ready) begin
            n_checks++;
            $display("FAIL idle_timeout: got %0d pending responses, required 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", {31'b0, rq.req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, rq.resp_valid}, 32'h0);
        chk("rst_resp_result", rq.resp_result, 32'h0);
        chk("rst_resp_err", {31'b0, rq.resp_err}, 32'h0);
        chk("rst_fpu_start", {31'b0, dp.fpu_start}, 32'h0);
        chk("rst_fpu_op", {28'b0, dp.fpu_operation}, {28'b0, FPU_HALF_ADD});
        chk("rst_fpu_a", dp.fpu_a, 32'h0);
        chk("rst_fpu_b", dp.fpu_b, 32'h0);
    endtask

    fpu_operation_t ops[10] = '{FPU_HALF_ADD, FPU_HALF_SUB, FPU_HALF_MUL, FPU_HALF_MADD, FPU_HALF_MSUB,
                                FPU_HALF_NMADD, FPU_HALF_NMSUB, FPU_HALF_DIV, FPU_HALF_SQRT, FPU_HALF_MAX};

    initial begin
        int n;
        int starts_before;
        nRST          = 1'b0;
        rq.req_valid  = 1'b0;
        rq.req_op     = FPU_HALF_ADD;
        rq.req_a      = '0;
        rq.req_b      = '0;
        rq.req_c      = '0;
        rq.resp_ready = 1'b0;
        dp.fpu_done   = 1'b0;
        dp.fpu_out    = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs();
        nRST = 1'b1;

        send(FPU_HALF_ADD, 32'h3C00, 32'h4000, 32'h0, 0, 0, 1);
        send(FPU_HALF_SUB, 32'h4200, 32'h3C00, 32'h0, 0, 0, 1);
        send(FPU_HALF_MUL, 32'h4000, 32'h4200, 32'h0, 0, 0, 1);
        wait_idle();
        chk("dir_add_model", {16'b0, r2h(h2r(16'h3C00) + h2r(16'h4000))}, 32'h4200);
        chk("dir_mul_model", {16'b0, r2h(h2r(16'h4000) * h2r(16'h4200))}, 32'h4600);

        send(FPU_HALF_MADD,  32'h4000, 32'h4200, 32'h3C00, 0, 0, 1);
        send(FPU_HALF_MSUB,  32'h4000, 32'h4200, 32'h3C00, 0, 0, 1);
        send(FPU_HALF_NMADD, 32'h4000, 32'h4200, 32'h3C00, 0, 0, 1);
        send(FPU_HALF_NMSUB, 32'h4000, 32'h4200, 32'h3C00, 0, 0, 1);
        wait_idle();
        chk("dir_nmadd_model", {16'b0, r2h(-h2r(r2h(h2r(16'h4000) * h2r(16'h4200))) - h2r(16'h3C00))}, 32'hC700);

        send(FPU_HALF_MADD, 32'h4000, 32'h4200, 32'h3C00, 0, 5, 1);
        send(FPU_HALF_ADD, 32'h3C00, 32'h3C00, 32'h0, 0, 0, 1);
        wait_idle();

        send(FPU_HALF_MADD, 32'h4000, 32'h4200, 32'h3C00, 3, 0, 1);
        send(FPU_HALF_ADD, 32'h4000, 32'h4000, 32'h0, TO, 0, 1);
        send(FPU_HALF_MADD, 32'h4000, 32'h4200, 32'h3C00, TO, 0, 1);
        send(FPU_HALF_SUB, 32'h4200, 32'h4000, 32'h0, TO - 1, 0, 1);
        wait_idle();

        starts_before = start_cnt;
        send(FPU_HALF_DIV, 32'h4000, 32'h4200, 32'h0, 0, 0, 1);
        send(fpu_operation_t'(4'd15), 32'h4000, 32'h4200, 32'h0, 0, 0, 1);
        wait_idle();
        chk("unsupported_no_start", start_cnt - starts_before, 32'h0);

        send(FPU_HALF_MADD, 32'h4000, 32'h4200, 32'h3C00, 3, 0, 0);
        n = 0;
        while (!(dp.fpu_start && dp.fpu_operation == FPU_HALF_ADD) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("reached_step2", {31'b0, dp.fpu_start}, 32'h1);
        nRST = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (4) @(negedge CLK);
        chk("post_rst_req_ready", {31'b0, rq.req_ready}, 32'h1);
        chk("post_rst_no_resp", {31'b0, rq.resp_valid}, 32'h0);
        send(FPU_HALF_ADD, 32'hFFFF3C00, 32'hFFFF4000, 32'hFFFF0000, 0, 0, 1);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            int d = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 4));
            send(ops[$urandom_range(0, 9)],
                 {16'($urandom), rand_half()}, {16'($urandom), rand_half()}, {16'($urandom), rand_half()},
                 d, int'($urandom_range(0, 2)), 1);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
